// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial memory arbiter: request type fields,
// size codes and controller states.
package mem_pkg;

  localparam int TYPE_WR_BIT = 3;
  localparam int TYPE_ZX_BIT = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Reserved size code 2'b11 moves a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant among eligible requesters, with the
// priority pointer moving past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 accept,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    logic hit;
    idx       = 0;
    hit       = 1'b0;
    grant     = '0;
    grant_idx = ptr_q;
    // Walk from the farthest offset down so the port nearest the pointer wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NUM_PORTS;
      if (req[idx]) begin
        grant_idx = IDX_W'(idx);
        hit       = 1'b1;
      end
    end
    if (hit) grant[grant_idx] = 1'b1;

    ptr_d = ptr_q;
    if (accept && hit)
      ptr_d = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-port arbiter onto a byte-wide memory bus: grants one requester at a
// time and serialises its byte/half/word access little-endian.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int                   NUM_PORTS  = 2,
  parameter int                   ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    IO_BASE    = ADDR_W'(32'h0003_0000),
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = NUM_PORTS'(2'b01)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic                      io_buffer_full,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [ADDR_W-1:0]         mem_a,
  output logic                      mem_wr,
  input  logic [NUM_PORTS-1:0]      req_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*4-1:0]    req_type,
  input  logic [NUM_PORTS*32-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]      req_rdy,
  output logic [31:0]               req_rdata
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        type_q, type_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [31:0]       rbuf_q, rbuf_d;

  logic [NUM_PORTS-1:0] elig, grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 accept;
  logic [2:0]           n_bytes, cnt_m1;
  logic                 io_stall;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                         input logic zx);
    case (sz)
      SZ_BYTE: return zx ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: return zx ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // IO writes are held back while the IO buffer is full; other ports may still win.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig[p] = req_en[p] & ~(req_type[p*4 + TYPE_WR_BIT] &
                              (req_addr[p*ADDR_W +: ADDR_W] >= IO_BASE) & io_buffer_full);
    end
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .clk       (clk_in),
    .rst       (rst_in),
    .req       (elig),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    type_d   = type_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    rbuf_d   = rbuf_q;
    accept   = 1'b0;
    n_bytes  = size_bytes(type_q[1:0]);
    cnt_m1   = cnt_q - 3'd1;
    io_stall = (addr_q >= IO_BASE) && io_buffer_full;

    if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            accept  = 1'b1;
            addr_d  = req_addr[grant_idx*ADDR_W +: ADDR_W];
            type_d  = req_type[grant_idx*4 +: 4];
            wdata_d = req_wdata[grant_idx*32 +: 32];
            owner_d = grant_idx;
            rbuf_d  = '0;
            cnt_d   = '0;
            state_d = req_type[grant_idx*4 + TYPE_WR_BIT] ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          // Read data returns one cycle after its address.
          if (cnt_q != 3'd0) rbuf_d[{cnt_m1[1:0], 3'b000} +: 8] = mem_din;
          if (cnt_q == n_bytes) state_d = ST_DONE;
          else                  cnt_d   = cnt_q + 3'd1;
        end
        ST_WRITE: begin
          if (!io_stall) begin
            if (cnt_q == n_bytes - 3'd1) state_d = ST_DONE;
            else                         cnt_d   = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Squash of a cancellable read wins even while the bus is frozen.
    if (state_q == ST_READ && flush && FLUSH_MASK[owner_q]) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
      owner_q <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    req_rdy   = '0;
    req_rdata = '0;
    case (state_q)
      ST_READ: begin
        if (cnt_q < n_bytes) mem_a = addr_q + ADDR_W'(cnt_q);
      end
      ST_WRITE: begin
        if (!io_stall) begin
          mem_a    = addr_q + ADDR_W'(cnt_q);
          mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr   = rdy_in;
        end
      end
      ST_DONE: begin
        req_rdy[owner_q] = 1'b1;
        if (!type_q[TYPE_WR_BIT]) req_rdata = extend(rbuf_q, type_q[1:0], type_q[TYPE_ZX_BIT]);
      end
      default: ;
    endcase
  end

endmodule
